rr_arb_8b: RTL and testbench

// Round-robin arbiter sharing one datapath resource among N requesters.
// - Samples a request vector and issues a registered one-hot grant plus its encoded index.
// - Holds the grant until the owner signals done, drops its request, or times out.
// - The downstream mux selects on gnt_idx_o; the upstream enable gates on gnt_o.
//

---
 rtl/rr_arb_8b.sv | 124 ++++++++++++
 tb/tb_rr_arb_8b.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rr_arb_8b.sv
// Round-robin arbiter: grants one requester at a time from a rotating priority pointer,
// holding the grant until done, request withdrawal, or watchdog expiry.
module rr_arb_8b #(
  parameter int N       = 8,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N-1:0]     req_i,
  input  logic             done_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o,
  output logic             timeout_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? {CNT_W{1'b0}} : CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;
  logic [IDX_W:0]   win_s;
  logic             owner_req_s;
  logic             wd_hit_s;

  // Scan from ptr upward (mod N); reverse iteration lets the smallest offset win.
  // Result MSB flags that any request was found.
  function automatic logic [IDX_W:0] pick(input logic [N-1:0] req, input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0] res;
    int             idx;
    res = {(IDX_W+1){1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        res = {1'b1, IDX_W'(idx)};
      end
    end
    return res;
  endfunction

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    win_s       = pick(req_i, ptr_q);
    owner_req_s = req_i[gnt_idx_q];
    wd_hit_s    = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        if (win_s[IDX_W]) begin
          state_d     = GRANT;
          gnt_d       = {{(N-1){1'b0}}, 1'b1} << win_s[IDX_W-1:0];
          gnt_idx_d   = win_s[IDX_W-1:0];
          gnt_valid_d = 1'b1;
          cnt_d       = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (done_i || !owner_req_s || wd_hit_s) begin
          // Watchdog pulse only when it is the deciding release cause.
          timeout_d   = !done_i && owner_req_s;
          state_d     = IDLE;
          gnt_d       = {N{1'b0}};
          gnt_idx_d   = {IDX_W{1'b0}};
          gnt_valid_d = 1'b0;
          ptr_d       = (gnt_idx_q == IDX_LAST) ? {IDX_W{1'b0}} : gnt_idx_q + IDX_W'(1);
        end else begin
          cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = {N{1'b0}};
        gnt_idx_d   = {IDX_W{1'b0}};
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      ptr_q       <= {IDX_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      gnt_q       <= {N{1'b0}};
      gnt_idx_q   <= {IDX_W{1'b0}};
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = gnt_idx_q;
  assign gnt_valid_o = gnt_valid_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_rr_arb_8b.sv
// Scoreboard bench for rr_arb_8b: directed steps push the expected post-edge outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_rr_arb_8b;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       v;
    logic       t;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t me;

  rr_arb_8b #(.N(8), .IDX_W(3), .TIMEOUT(4), .CNT_W(3)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .req_i      (req),
    .done_i     (done),
    .gnt_o      (gnt),
    .gnt_idx_o  (gnt_idx),
    .gnt_valid_o(gnt_valid),
    .timeout_o  (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation whose target cycle has arrived.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      me = q.pop_front();
      checks++;
      if (me.cyc != cyc || gnt !== me.gnt || gnt_idx !== me.idx ||
          gnt_valid !== me.v || timeout !== me.t) begin
        failures++;
        $display("FAIL %s cyc=%0d: got gnt=%h idx=%0d valid=%b timeout=%b, want gnt=%h idx=%0d valid=%b timeout=%b",
                 me.name, cyc, gnt, gnt_idx, gnt_valid, timeout, me.gnt, me.idx, me.v, me.t);
      end
    end
  end

  // Drive inputs for the next edge; ei < 0 means idle is expected after it.
  task automatic step(input logic rn, input logic [7:0] r, input logic d,
                      input int ei, input logic et, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn;
    req   = r;
    done  = d;
    e.cyc = cyc + 1;
    if (ei < 0) begin
      e.gnt = 8'h00;
      e.idx = 3'd0;
      e.v   = 1'b0;
    end else begin
      e.gnt = 8'd1 << ei;
      e.idx = 3'(ei);
      e.v   = 1'b1;
    end
    e.t    = et;
    e.name = nm;
    q.push_back(e);
  endtask

  initial begin
    // T1 reset with all requesting, then first grant goes to 0
    step(1'b0, 8'hFF, 1'b0, -1, 1'b0, "t1_reset0");
    step(1'b0, 8'hFF, 1'b0, -1, 1'b0, "t1_reset1");
    step(1'b1, 8'hFF, 1'b1,  0, 1'b0, "t1_first_grant");
    step(1'b1, 8'hFF, 1'b1, -1, 1'b0, "t1_release");

    // T3 rotation 1..7 then wrap to 0, idle between each
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 8'hFF, 1'b1, k % 8, 1'b0, "t3_rot_grant");
      step(1'b1, 8'hFF, 1'b1, -1,    1'b0, "t3_rot_idle");
    end

    // T2 single requester 4 held three cycles (ptr=1 going in)
    step(1'b1, 8'h10, 1'b0,  4, 1'b0, "t2_grant_c1");
    step(1'b1, 8'h10, 1'b0,  4, 1'b0, "t2_grant_c2");
    step(1'b1, 8'h10, 1'b0,  4, 1'b0, "t2_grant_c3");
    step(1'b1, 8'h10, 1'b1, -1, 1'b0, "t2_idle_c4");
    step(1'b1, 8'h00, 1'b0, -1, 1'b0, "t2_idle_noreq");
    step(1'b1, 8'h21, 1'b0,  5, 1'b0, "t2_ptr5");
    step(1'b1, 8'h21, 1'b1, -1, 1'b0, "t2_ptr5_rel");

    // T4 wrap and skip from ptr=6
    step(1'b1, 8'h05, 1'b0,  0, 1'b0, "t4_wrap_to0");
    step(1'b1, 8'h05, 1'b1, -1, 1'b0, "t4_rel0");
    step(1'b1, 8'h05, 1'b0,  2, 1'b0, "t4_skip_to2");
    step(1'b1, 8'h05, 1'b1, -1, 1'b0, "t4_rel2");

    // T5 abort by owner 3 in its second grant cycle
    step(1'b1, 8'h08, 1'b0,  3, 1'b0, "t5_grant_c1");
    step(1'b1, 8'h08, 1'b0,  3, 1'b0, "t5_grant_c2");
    step(1'b1, 8'h00, 1'b0, -1, 1'b0, "t5_abort");
    step(1'b1, 8'h18, 1'b0,  4, 1'b0, "t5_ptr4");
    step(1'b1, 8'hF7, 1'b0,  4, 1'b0, "t5_nonowner_change");
    step(1'b1, 8'h18, 1'b1, -1, 1'b0, "t5_rel4");

    // T6 watchdog on owner 1 (ptr=5): four grant cycles then forced release
    step(1'b1, 8'h02, 1'b0,  1, 1'b0, "t6_grant_c1");
    step(1'b1, 8'h02, 1'b0,  1, 1'b0, "t6_grant_c2");
    step(1'b1, 8'h02, 1'b0,  1, 1'b0, "t6_grant_c3");
    step(1'b1, 8'h02, 1'b0,  1, 1'b0, "t6_grant_c4");
    step(1'b1, 8'h02, 1'b0, -1, 1'b1, "t6_timeout_pulse");
    step(1'b1, 8'h06, 1'b0,  2, 1'b0, "t6_ptr2_pulse_gone");
    step(1'b0, 8'h06, 1'b0, -1, 1'b0, "t6_reset_midgrant");
    step(1'b1, 8'hFF, 1'b0,  0, 1'b0, "t6_after_reset_idx0");
    step(1'b1, 8'hFF, 1'b1, -1, 1'b0, "t6_after_reset_rel");

    // done wins over watchdog on the last allowed cycle (ptr=1)
    step(1'b1, 8'h02, 1'b0,  1, 1'b0, "prio_grant_c1");
    step(1'b1, 8'h02, 1'b0,  1, 1'b0, "prio_grant_c2");
    step(1'b1, 8'h02, 1'b0,  1, 1'b0, "prio_grant_c3");
    step(1'b1, 8'h02, 1'b0,  1, 1'b0, "prio_grant_c4");
    step(1'b1, 8'h02, 1'b1, -1, 1'b0, "prio_done_no_timeout");
    step(1'b1, 8'h00, 1'b0, -1, 1'b0, "final_idle");

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
